// File: rtl/cache_mesi_arbiter_if.sv
// Bus bundle for cache_mesi_arbiter: per-cache request/response ports, the shared
// directory/memory channel and the invalidate broadcast.
interface cache_mesi_arbiter_if #(
   parameter int NUM_PORTS  = 4,
   parameter int ADDR_WIDTH = 32
);
   localparam int ID_W = $clog2(NUM_PORTS);

   logic [NUM_PORTS-1:0]            req_valid;
   logic [NUM_PORTS-1:0]            req_ready;
   logic [2*NUM_PORTS-1:0]          req_op;
   logic [ADDR_WIDTH*NUM_PORTS-1:0] req_addr;

   logic                  mem_req_valid;
   logic                  mem_req_ready;
   logic [1:0]            mem_req_op;
   logic [ADDR_WIDTH-1:0] mem_req_addr;
   logic [ID_W-1:0]       mem_req_id;

   logic       mem_resp_valid;
   logic       mem_resp_ready;
   logic [1:0] mem_resp_op;

   logic [NUM_PORTS-1:0] resp_valid;
   logic [NUM_PORTS-1:0] resp_ready;
   logic [1:0]           resp_op;

   logic [NUM_PORTS-1:0]  inval_valid;
   logic [ADDR_WIDTH-1:0] inval_addr;

   // Arbiter side.
   modport slave (
      input  req_valid, req_op, req_addr, mem_req_ready, mem_resp_valid, mem_resp_op, resp_ready,
      output req_ready, mem_req_valid, mem_req_op, mem_req_addr, mem_req_id, mem_resp_ready,
             resp_valid, resp_op, inval_valid, inval_addr
   );

   // Caches + directory side.
   modport master (
      output req_valid, req_op, req_addr, mem_req_ready, mem_resp_valid, mem_resp_op, resp_ready,
      input  req_ready, mem_req_valid, mem_req_op, mem_req_addr, mem_req_id, mem_resp_ready,
             resp_valid, resp_op, inval_valid, inval_addr
   );
endinterface

// File: rtl/cache_mesi_arbiter.sv
// Round-robin arbiter sharing one MESI channel between NUM_PORTS caches, one transaction in flight.
// Optional invalidate broadcast on exclusive requests: CACHE_MESI_ARBITER_INVALIDATE_EN.
module cache_mesi_arbiter #(
   parameter int NUM_PORTS  = 4,
   parameter int ADDR_WIDTH = 32
) (
   input logic                  clk,
   input logic                  rst,
   cache_mesi_arbiter_if.slave  bus
);
   localparam int ID_W = $clog2(NUM_PORTS);

   typedef enum logic [1:0] {OP_SHARED, OP_EXCL, OP_EXCL_DATA, OP_EVICT} cache_mesi_operation_t;
   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESPOND} state_t;

   state_t                state, state_d;
   logic [ID_W-1:0]       rr_ptr, g_q, gnt;
   cache_mesi_operation_t op_q;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [1:0]            rsp_op_q;
   logic                  any_vld;
   logic [NUM_PORTS-1:0]  g_oh, req_ready_c, resp_valid_c;

   logic [NUM_PORTS-1:0][1:0]            op_a;
   logic [NUM_PORTS-1:0][ADDR_WIDTH-1:0] addr_a;

   for (genvar i = 0; i < NUM_PORTS; i++) begin : g_unpack
      assign op_a[i]   = bus.req_op[2*i +: 2];
      assign addr_a[i] = bus.req_addr[ADDR_WIDTH*i +: ADDR_WIDTH];
   end

   // Scan downward so the lowest offset from rr_ptr wins.
   always_comb begin
      logic [ID_W:0] sum;
      any_vld = |bus.req_valid;
      gnt     = '0;
      sum     = '0;
      for (int k = NUM_PORTS-1; k >= 0; k--) begin
         sum = {1'b0, rr_ptr} + (ID_W+1)'(k);
         if (sum >= (ID_W+1)'(NUM_PORTS)) sum = sum - (ID_W+1)'(NUM_PORTS);
         if (bus.req_valid[sum[ID_W-1:0]]) gnt = sum[ID_W-1:0];
      end
   end

   always_comb begin
      state_d = state;
      case (state)
         IDLE:    if (any_vld)                state_d = ISSUE;
         ISSUE:   if (bus.mem_req_ready)      state_d = WAIT;
         WAIT:    if (bus.mem_resp_valid)     state_d = RESPOND;
         RESPOND: if (bus.resp_ready[g_q])    state_d = IDLE;
         default:                             state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         rr_ptr   <= '0;
         g_q      <= '0;
         op_q     <= OP_SHARED;
         addr_q   <= '0;
         rsp_op_q <= '0;
      end else begin
         state <= state_d;
         if (state == IDLE && any_vld) begin
            g_q    <= gnt;
            op_q   <= cache_mesi_operation_t'(op_a[gnt]);
            addr_q <= addr_a[gnt];
         end
         if (state == WAIT && bus.mem_resp_valid) rsp_op_q <= bus.mem_resp_op;
         if (state == RESPOND && bus.resp_ready[g_q])
            rr_ptr <= (g_q == ID_W'(NUM_PORTS-1)) ? '0 : g_q + 1'b1;
      end
   end

   assign g_oh = {{(NUM_PORTS-1){1'b0}}, 1'b1} << g_q;

   // rst gates the only input-driven grant so outputs read 0 during reset.
   always_comb begin
      req_ready_c  = '0;
      resp_valid_c = '0;
      if (state == IDLE && any_vld && !rst) req_ready_c[gnt] = 1'b1;
      if (state == RESPOND) resp_valid_c = g_oh;
   end

   assign bus.req_ready      = req_ready_c;
   assign bus.mem_req_valid  = (state == ISSUE);
   assign bus.mem_req_op     = (state == ISSUE) ? op_q   : 2'b00;
   assign bus.mem_req_addr   = (state == ISSUE) ? addr_q : '0;
   assign bus.mem_req_id     = (state == ISSUE) ? g_q    : '0;
   assign bus.mem_resp_ready = (state == WAIT);
   assign bus.resp_valid     = resp_valid_c;
   assign bus.resp_op        = (state == RESPOND) ? rsp_op_q : 2'b00;

`ifdef CACHE_MESI_ARBITER_INVALIDATE_EN
   logic [NUM_PORTS-1:0]  inval_v;
   logic [ADDR_WIDTH-1:0] inval_a;

   // Pulse on the cycle the exclusive request is handed to the directory.
   always_comb begin
      inval_v = '0;
      inval_a = '0;
      if (state == ISSUE && bus.mem_req_ready && (op_q == OP_EXCL || op_q == OP_EXCL_DATA)) begin
         inval_v = ~g_oh;
         inval_a = addr_q;
      end
   end

   assign bus.inval_valid = inval_v;
   assign bus.inval_addr  = inval_a;
`else
   assign bus.inval_valid = '0;
   assign bus.inval_addr  = '0;
`endif
endmodule

// File: tb/tb_cache_mesi_arbiter.sv
// Directed + randomized bench for cache_mesi_arbiter against a transaction-level reference model.
module tb_cache_mesi_arbiter;
   localparam int N  = 4;
   localparam int AW = 32;
   localparam logic [1:0] SH = 2'd0, EX = 2'd1, EXD = 2'd2, EV = 2'd3;

`ifdef CACHE_MESI_ARBITER_INVALIDATE_EN
   localparam bit INV_EN = 1'b1;
`else
   localparam bit INV_EN = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   cache_mesi_arbiter_if #(.NUM_PORTS(N), .ADDR_WIDTH(AW)) bus ();
   cache_mesi_arbiter #(.NUM_PORTS(N), .ADDR_WIDTH(AW)) dut (.clk(clk), .rst(rst), .bus(bus));

   int checks = 0;
   int errors = 0;
   int ptr    = 0;   // model round-robin pointer

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [N-1:0] onehot(input int p);
      logic [N-1:0] v;
      v = '0;
      v[p] = 1'b1;
      return v;
   endfunction

   // Grant rule: first requesting port at or after the pointer, wrapping.
   function automatic int model_grant(input logic [N-1:0] m, input int p);
      for (int k = 0; k < N; k++)
         if (m[(p + k) % N]) return (p + k) % N;
      return -1;
   endfunction

   task automatic set_req(input int port, input logic [1:0] op, input logic [AW-1:0] addr);
      bus.req_op[2*port +: 2]    = op;
      bus.req_addr[AW*port +: AW] = addr;
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_req_ready"},  bus.req_ready, 0);
      check({tag, "_mreq_valid"}, bus.mem_req_valid, 0);
      check({tag, "_mreq_op"},    bus.mem_req_op, 0);
      check({tag, "_mreq_addr"},  bus.mem_req_addr, 0);
      check({tag, "_mreq_id"},    bus.mem_req_id, 0);
      check({tag, "_mresp_rdy"},  bus.mem_resp_ready, 0);
      check({tag, "_resp_valid"}, bus.resp_valid, 0);
      check({tag, "_resp_op"},    bus.resp_op, 0);
      check({tag, "_inval_v"},    bus.inval_valid, 0);
      check({tag, "_inval_a"},    bus.inval_addr, 0);
   endtask

   // Full transaction starting at a negedge in IDLE; ends at a negedge back in IDLE.
   task automatic do_txn(input logic [N-1:0] mask, input int mwait, input int rwait,
                         input logic [1:0] rop, input bit hold, output int obs_g);
      int g;
      logic [1:0]    eop;
      logic [AW-1:0] eaddr;
      logic [N-1:0]  einv;
      bus.req_valid = mask;
      #1;
      g     = model_grant(mask, ptr);
      eop   = bus.req_op[2*g +: 2];
      eaddr = bus.req_addr[AW*g +: AW];
      obs_g = -1;
      for (int k = 0; k < N; k++) if (bus.req_ready[k]) obs_g = k;
      check("grant", bus.req_ready, onehot(g));
      check("idle_mreq_valid", bus.mem_req_valid, 0);
      check("idle_resp_valid", bus.resp_valid, 0);
      @(negedge clk);
      if (!hold) bus.req_valid = '0;
      for (int c = 0; c <= mwait; c++) begin
         if (c > 0) @(negedge clk);
         bus.mem_req_ready  = (c == mwait);
         bus.mem_resp_valid = (c < mwait) ? 1'($urandom_range(0, 1)) : 1'b0;
         bus.mem_resp_op    = 2'($urandom);
         #1;
         check("mreq_valid", bus.mem_req_valid, 1);
         check("mreq_id",    bus.mem_req_id, g);
         check("mreq_op",    bus.mem_req_op, eop);
         check("mreq_addr",  bus.mem_req_addr, eaddr);
         check("issue_mresp_rdy", bus.mem_resp_ready, 0);
         check("issue_req_ready", bus.req_ready, 0);
         check("issue_resp_valid", bus.resp_valid, 0);
         einv = (INV_EN && c == mwait && (eop == EX || eop == EXD)) ? ~onehot(g) : '0;
         check("inval_valid", bus.inval_valid, einv);
         check("inval_addr",  bus.inval_addr, (einv != 0) ? eaddr : '0);
      end
      @(negedge clk);
      bus.mem_req_ready  = 1'b0;
      bus.mem_resp_valid = 1'b1;
      bus.mem_resp_op    = rop;
      #1;
      check("wait_mresp_rdy", bus.mem_resp_ready, 1);
      check("wait_mreq_valid", bus.mem_req_valid, 0);
      check("wait_inval", bus.inval_valid, 0);
      @(negedge clk);
      for (int c = 0; c <= rwait; c++) begin
         if (c > 0) @(negedge clk);
         bus.mem_resp_valid = 1'($urandom_range(0, 1));
         bus.mem_resp_op    = 2'($urandom);
         bus.resp_ready     = (c == rwait) ? onehot(g) : ~onehot(g);
         #1;
         check("resp_valid", bus.resp_valid, onehot(g));
         check("resp_op",    bus.resp_op, rop);
         check("resp_mresp_rdy", bus.mem_resp_ready, 0);
         check("resp_mreq_valid", bus.mem_req_valid, 0);
      end
      @(negedge clk);
      bus.resp_ready     = '0;
      bus.mem_resp_valid = 1'b0;
      ptr = (g + 1) % N;
   endtask

   initial begin
      int g;
      int start;
      rst = 1'b1;
      bus.req_valid = '0; bus.req_op = '0; bus.req_addr = '0;
      bus.mem_req_ready = 1'b0; bus.mem_resp_valid = 1'b0; bus.mem_resp_op = '0;
      bus.resp_ready = '0;
      repeat (2) @(negedge clk);
      check_zero("reset");
      rst = 1'b0;
      @(negedge clk);

      // Single transaction, zero-wait memory
      set_req(1, SH, 32'h1000);
      do_txn(4'b0010, 0, 0, SH, 1'b0, g);
      check("single_port", g, 1);

      // Reset in WAIT with port 2 granted
      set_req(2, EX, 32'h2222);
      bus.req_valid = 4'b0100;
      #1 check("rst_grant", bus.req_ready, 4'b0100);
      @(negedge clk);
      bus.req_valid = '0;
      bus.mem_req_ready = 1'b1;
      #1 check("rst_issue", bus.mem_req_id, 2);
      @(negedge clk);
      bus.mem_req_ready = 1'b0;
      #1 check("rst_in_wait", bus.mem_resp_ready, 1);
      rst = 1'b1;
      bus.req_valid = 4'b1001;
      #1 check_zero("midrst");
      @(negedge clk);
      check_zero("midrst_hold");
      rst = 1'b0;
      ptr = 0;
      set_req(0, SH, 32'h10); set_req(3, SH, 32'h30);
      do_txn(4'b1001, 0, 0, SH, 1'b0, g);
      check("post_rst_grant", g, 0);

      // Pointer wrap: grant 3, then 0 wins over 3
      set_req(3, EXD, 32'h40);
      do_txn(4'b1000, 0, 0, EX, 1'b0, g);
      check("wrap_grant3", g, 3);

      // Round robin, all ports continuously valid
      for (int p = 0; p < N; p++) set_req(p, 2'($urandom), $urandom);
      start = ptr;
      for (int i = 0; i < 8; i++) begin
         do_txn(4'b1111, 0, 0, 2'($urandom), 1'b1, g);
         check("rr_order", g, (start + i) % N);
      end
      bus.req_valid = '0;

      // Eviction, then pointer must be 1
      set_req(0, EV, 32'h800);
      do_txn(4'b0001, 0, 0, EV, 1'b0, g);
      check("evict_port", g, 0);
      set_req(1, SH, 32'h900);
      do_txn(4'b0011, 0, 0, SH, 1'b0, g);
      check("evict_ptr", g, 1);

      // Back-pressure on both sides, exactly one transaction completes
      set_req(2, EXD, 32'hABC0);
      do_txn(4'b0100, 5, 3, EXD, 1'b0, g);
      repeat (3) begin
         #1 check_zero("bp_after");
         @(negedge clk);
      end

      // Single requester re-granted right after its response
      set_req(1, EX, 32'h55);
      do_txn(4'b0010, 0, 0, SH, 1'b1, g);
      do_txn(4'b0010, 1, 1, EX, 1'b1, g);
      check("regrant", g, 1);
      bus.req_valid = '0;

      // Invalidate targeted case
      set_req(3, EXD, 32'h40);
      do_txn(4'b1000, 0, 0, EXD, 1'b0, g);

      // Randomized traffic
      for (int i = 0; i < 24; i++) begin
         logic [N-1:0] m;
         for (int p = 0; p < N; p++) set_req(p, 2'($urandom), $urandom);
         m = 4'($urandom_range(1, 15));
         do_txn(m, $urandom_range(0, 3), $urandom_range(0, 3), 2'($urandom), 1'b0, g);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
